sevenseg_scan_driver: RTL and testbench
=======================================

Name: sevenseg_scan_driver

Overview:
- Display-side reader for the stopwatch: takes the four BCD time digits the stopwatch counter produces and drives a 4-digit, common-anode, multiplexed seven-segment display.
- Shadow-latches the digits once per frame so digits never tear mid-scan.
- Supports per-digit blanking, blinking (for pause indication) and decimal points.
- Sits between the stopwatch core and the board pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit is lit (>=2); 100 MHz gives 1 kHz digit rate, 250 Hz frame rate.
- BLINK_DIV, 50000000, clk cycles per blink phase toggle (>=2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- digits  input  16  BCD digits; [3:0]=digit0 (rightmost) .. [15:12]=digit3 (leftmost)
- blank_mask  input  4  bit i=1: digit i always dark
- blink_mask  input  4  bit i=1: digit i dark while blink_phase=1
- dp_mask  input  4  bit i=1: decimal point lit on digit i
- seg  output  7  {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- an  output  4  anode enables, active-low, an[i] selects digit i
- frame_start  output  1  one-cycle pulse when shadow registers load

Behaviour:
- Clock and reset:
  - Single clock domain, rising edge.
  - rst is asynchronous and active-high, and may assert at any cycle including mid-scan.
- Reset values:
  - an=4'b1111, seg=7'b1111111, dp=1, frame_start=0.
  - idx=0, refresh_cnt=0, blink_cnt=0, blink_phase=0.
  - Shadow digits/blank/blink/dp=0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps; width $clog2(REFRESH_DIV).
  - On the wrap cycle, idx advances 0->1->2->3->0.
- Frame boundary:
  - Occurs on the wrap cycle with idx=3.
  - On that edge, idx becomes 0 and the shadow registers capture digits, blank_mask, blink_mask and dp_mask.
  - frame_start is registered high for exactly that next cycle.
  - Input changes between boundaries are invisible until the next boundary.
- Blink counter:
  - Counts 0..BLINK_DIV-1 and wraps, toggling blink_phase on wrap.
  - Free-running and independent of the refresh counter.
- Output stage (registered every cycle from idx, shadow and blink_phase; 1-cycle latency):
  - dark = shadow_blank[idx] | (shadow_blink[idx] & blink_phase).
  - an = ~(4'b0001 << idx) when not dark, else 4'b1111.
  - seg = decode(shadow_digit[idx]); forced to 7'b1111111 when dark.
  - dp = ~shadow_dp[idx]; forced to 1 when dark.
- Decode table (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 10..15 render dash = 0111111.
- Sequencing:
  - Exactly one an bit is low at a time, or none.
  - No ghosting requirement beyond this; no dead-time insertion.
- After reset release:
  - The first clock edge gives an=1110, seg=1000000, dp=1; the display shows "0000" until the first frame boundary.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock; scanning restarts at digit0.

Test Plan (REFRESH_DIV=4, BLINK_DIV=64):
- Reset and first frame:
  - Assert rst -> an=1111, seg=1111111, dp=1, frame_start=0 asynchronously.
  - Release with digits=16'h1234 -> first edge an=1110, seg=1000000 (shadow 0).
  - frame_start pulses once after 16 cycles.
- Scan order, frame after shadow load:
  - an = 1110, 1101, 1011, 0111, each held 4 cycles.
  - seg = 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1).
- Tear-free latch:
  - Change digits to 16'h5678 while idx=1 -> remainder of frame still shows 1234.
  - Next frame shows 8,7,6,5 (seg 0000000, 1111000, 0000010, 0010010).
- Blink and blank:
  - blink_mask=0001 -> digit0 an stays 1111 whenever blink_phase=1 (64-cycle windows); normal otherwise.
  - blank_mask=1000 -> digit3 slot always an=1111.
- Dash and dp:
  - digit0=4'hB -> seg=0111111.
  - dp_mask=0100 -> dp=0 only while an=1011.
- Reset mid-scan: assert rst while idx=2 -> outputs return to reset values immediately; after release, scan restarts at an=1110 showing 0.

Source files
------------

// File: rtl/sevenseg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver_if
//   Bundles the stopwatch-side digit/mask inputs and the board-side display
//   outputs of the seven-segment scan driver.
//
//   digits      : 4 BCD digits, [3:0]=digit0 (rightmost) .. [15:12]=digit3
//   blank_mask  : bit i=1 keeps digit i dark
//   blink_mask  : bit i=1 darkens digit i while the blink phase is high
//   dp_mask     : bit i=1 lights the decimal point of digit i
//   seg         : segments {g,f,e,d,c,b,a}, active-low
//   dp          : decimal point, active-low
//   an          : anode enables, active-low, an[i] selects digit i
//   frame_start : one-cycle pulse when the shadow registers load
//
//   master : the side that supplies digits/masks and watches the display
//   slave  : the scan driver itself
// -----------------------------------------------------------------------------
interface sevenseg_scan_driver_if;
  logic [15:0] digits;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic [3:0]  dp_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  modport master (
    output digits, blank_mask, blink_mask, dp_mask,
    input  seg, dp, an, frame_start
  );

  modport slave (
    input  digits, blank_mask, blink_mask, dp_mask,
    output seg, dp, an, frame_start
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver
//   Drives a 4-digit common-anode multiplexed seven-segment display from the
//   stopwatch's BCD digits. Each digit is lit for REFRESH_DIV cycles; after
//   digit3 the frame ends and the digits and masks are shadow-latched, so a
//   digit change can never tear a frame. A free-running blink counter toggles
//   blink_phase every BLINK_DIV cycles for pause indication.
//
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : sevenseg_scan_driver_if.slave (digits/masks in, seg/dp/an/frame_start out)
//
//   All display outputs are registered: one cycle of latency from the
//   scan index, shadow registers and blink phase.
// -----------------------------------------------------------------------------
module sevenseg_scan_driver #(
  parameter int REFRESH_DIV = 100000,  // clk cycles each digit is lit (>=2)
  parameter int BLINK_DIV   = 50000000 // clk cycles per blink phase (>=2)
) (
  input  logic                  clk,
  input  logic                  rst,
  sevenseg_scan_driver_if.slave bus
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    SEG_OFF      = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes render a dash.
  function automatic logic [6:0] decode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  logic [15:0]   sh_digits_q, sh_digits_d;
  logic [3:0]    sh_blank_q, sh_blank_d;
  logic [3:0]    sh_blink_q, sh_blink_d;
  logic [3:0]    sh_dp_q, sh_dp_d;

  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_start_q, frame_start_d;

  logic          refresh_wrap;
  logic          blink_wrap;
  logic          frame_edge;
  logic          dark;
  logic [3:0]    cur_digit;

  assign refresh_wrap = (refresh_cnt_q == REFRESH_LAST);
  assign blink_wrap   = (blink_cnt_q == BLINK_LAST);
  // The frame ends when the last digit's slot expires.
  assign frame_edge   = refresh_wrap && (idx_q == 2'd3);

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    refresh_cnt_d = refresh_cnt_q + RW'(1);
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q + BW'(1);
    blink_phase_d = blink_phase_q;
    sh_digits_d   = sh_digits_q;
    sh_blank_d    = sh_blank_q;
    sh_blink_d    = sh_blink_q;
    sh_dp_d       = sh_dp_q;
    frame_start_d = frame_edge;

    if (refresh_wrap) begin
      refresh_cnt_d = '0;
      idx_d         = idx_q + 2'd1;  // 3 wraps naturally to 0
    end

    if (blink_wrap) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end

    if (frame_edge) begin
      sh_digits_d = bus.digits;
      sh_blank_d  = bus.blank_mask;
      sh_blink_d  = bus.blink_mask;
      sh_dp_d     = bus.dp_mask;
    end
  end

  // Output stage looks only at the current index, shadow copy and blink phase.
  assign cur_digit = sh_digits_q[{idx_q, 2'b00} +: 4];
  assign dark      = sh_blank_q[idx_q] | (sh_blink_q[idx_q] & blink_phase_q);

  always_comb begin
    an_d  = dark ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = dark ? SEG_OFF : decode(cur_digit);
    dp_d  = dark ? 1'b1    : ~sh_dp_q[idx_q];
  end

  // NOTE: the shadow registers are reset along with everything else; they are
  // a handful of flops, and a defined "0000" after reset is what users see.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      sh_digits_q   <= '0;
      sh_blank_q    <= '0;
      sh_blink_q    <= '0;
      sh_dp_q       <= '0;
      an_q          <= 4'b1111;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      refresh_cnt_q <= refresh_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      sh_digits_q   <= sh_digits_d;
      sh_blank_q    <= sh_blank_d;
      sh_blink_q    <= sh_blink_d;
      sh_dp_q       <= sh_dp_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan_driver
//   Bench for sevenseg_scan_driver with REFRESH_DIV=4, BLINK_DIV=64.
//   The reference model derives everything from k, the number of clock edges
//   since reset release: the lit digit is (k / REFRESH_DIV) mod 4, the blink
//   phase is (k / BLINK_DIV) mod 2, and a frame ends on every FRAME-th edge,
//   when the modelled shadow copy takes the inputs present before that edge.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_driver;

  localparam int REFRESH_DIV = 4;
  localparam int BLINK_DIV   = 64;
  localparam int FRAME       = 4 * REFRESH_DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  sevenseg_scan_driver_if bus ();

  sevenseg_scan_driver #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLINK_DIV   (BLINK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  int          k;
  logic [15:0] m_digits;
  logic [3:0]  m_blank, m_blink, m_dp;
  logic [6:0]  seg_tbl [16];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  task automatic model_clear();
    k        = 0;
    m_digits = '0;
    m_blank  = '0;
    m_blink  = '0;
    m_dp     = '0;
  endtask

  // Predict the outputs for the next edge, advance one clock, compare.
  task automatic tick();
    int         idx;
    bit         phase;
    bit         dark;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fs;

    idx   = (k / REFRESH_DIV) % 4;
    phase = ((k / BLINK_DIV) % 2) == 1;
    dark  = m_blank[idx] || (m_blink[idx] && phase);

    e_an = 4'b1111;
    if (!dark) e_an[idx] = 1'b0;
    e_seg = dark ? 7'b1111111 : seg_tbl[m_digits[idx*4 +: 4]];
    e_dp  = dark ? 1'b1 : ~m_dp[idx];
    e_fs  = (k % FRAME) == FRAME - 1;

    if (e_fs) begin
      m_digits = bus.digits;
      m_blank  = bus.blank_mask;
      m_blink  = bus.blink_mask;
      m_dp     = bus.dp_mask;
    end

    @(posedge clk);
    #1;
    k++;
    check("an",          16'(bus.an),          16'(e_an));
    check("seg",         16'(bus.seg),         16'(e_seg));
    check("dp",          16'(bus.dp),          16'(e_dp));
    check("frame_start", 16'(bus.frame_start), 16'(e_fs));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"},  16'(bus.an),          16'hF);
    check({tag, "_seg"}, 16'(bus.seg),         16'h7F);
    check({tag, "_dp"},  16'(bus.dp),          16'h1);
    check({tag, "_fs"},  16'(bus.frame_start), 16'h0);
  endtask

  // Assert reset between edges, confirm it acts without a clock, hold it
  // over a couple of edges, then release on a falling edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_reset_outputs({tag, "_held"});
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

    bus.digits     = 16'h0000;
    bus.blank_mask = 4'b0000;
    bus.blink_mask = 4'b0000;
    bus.dp_mask    = 4'b0000;
    model_clear();

    #2;
    do_reset("por");

    // First frame shows 0000; 1234 is picked up at the first boundary.
    bus.digits = 16'h1234;
    repeat (FRAME) tick();

    // Second frame shows 1234; 5678 arrives while digit1 is lit.
    repeat (5) tick();
    bus.digits = 16'h5678;
    repeat (FRAME - 5) tick();
    repeat (FRAME) tick();

    // Blink digit0 across several blink windows, then blank digit3 too.
    bus.blink_mask = 4'b0001;
    repeat (3 * BLINK_DIV) tick();
    bus.blank_mask = 4'b1000;
    repeat (2 * BLINK_DIV) tick();

    // Dash on a non-BCD digit and a decimal point on digit2.
    bus.blink_mask = 4'b0000;
    bus.blank_mask = 4'b0000;
    bus.digits     = 16'h567B;
    bus.dp_mask    = 4'b0100;
    repeat (2 * FRAME) tick();

    // Random digits and masks changed at random points in the scan.
    for (int i = 0; i < 60; i++) begin
      bus.digits     = 16'($urandom);
      bus.blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      bus.blink_mask = 4'($urandom);
      bus.dp_mask    = 4'($urandom);
      repeat ($urandom_range(1, 40)) tick();
    end

    // Reset while digit2 is lit; scanning must restart at digit0 showing 0.
    bus.blank_mask = 4'b0000;
    bus.blink_mask = 4'b0000;
    for (int guard = 0; guard < FRAME && ((k / REFRESH_DIV) % 4) != 2; guard++) tick();
    check("mid_idx_is_2", 16'((k / REFRESH_DIV) % 4), 16'd2);
    #2;
    do_reset("mid");
    bus.digits = 16'h9021;
    repeat (3 * FRAME) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
